// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin, credit-gated arbiter that shares the single
// leaf-to-BFT output link among NUM_OUT_PORTS user streams. Each accepted
// word becomes a registered BFT packet {valid, dest_leaf, dest_port, addr,
// payload}, where addr is a per-port wrapping write address.
// Optional statistics block: define LEAF_ARB_STATS_EN to build per-port sent
// counters, a credit-stall counter and a resend-stall counter behind stat_sel.
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  resend,
  input  logic                                  cfg_we,
  input  logic [2:0]                            cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic                                  credit_upd_vld,
  input  logic [2:0]                            credit_upd_port,
  input  logic [3:0]                            stat_sel,
  output logic [31:0]                           stat_data
);

  localparam int CW           = NUM_BRAM_ADDR_BITS + 1;
  localparam int PTR_W        = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int DEST_W       = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CREDIT_MAX_I = 1 << NUM_BRAM_ADDR_BITS;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_MAX_I);

  logic [CW-1:0]            credit     [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_nxt [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr       [NUM_OUT_PORTS];
  logic [DEST_W-1:0]        dest       [NUM_OUT_PORTS];
  logic [PTR_W-1:0]         rr_ptr, rr_ptr_nxt;
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic                     grant_vld;
  logic [PTR_W-1:0]         grant_idx;
  logic [PACKET_BITS-1:0]   pkt_nxt;

  // A port may be served when it has data, downstream space, and the link is not stalled.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2interface[i] && (credit[i] != '0) && !resend && !reset;
    end
  end

  // Round-robin search: first eligible port at or after the pointer wins.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_OUT_PORTS;
      if (!grant_vld && eligible[idx[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
  end

  // Decode the winner into the ack pulse, the next pointer and the outgoing packet.
  always_comb begin
    ack_interface2user = '0;
    rr_ptr_nxt         = rr_ptr;
    pkt_nxt            = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant_vld && grant_idx == PTR_W'(i)) begin
        ack_interface2user[i] = 1'b1;
        rr_ptr_nxt            = (i == NUM_OUT_PORTS - 1) ? '0 : PTR_W'(i + 1);
        pkt_nxt = {1'b1, dest[i], addr[i],
                   din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  // Credit bookkeeping: one credit per grant, a block of credits per update, capped at buffer depth.
  always_comb begin
    int sum;
    sum = 0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = int'(credit[i]);
      if (ack_interface2user[i]) sum = sum - 1;
      if (credit_upd_vld && credit_upd_port == 3'(i)) sum = sum + FREESPACE_UPDATE_SIZE;
      if (sum > CREDIT_MAX_I) sum = CREDIT_MAX_I;
      credit_nxt[i] = CW'(sum);
    end
  end

  // Registered state: pointer, output packet, and per-port credit/address/destination.
  // NOTE: the per-port arrays are small register files, not RAM, so they are
  // cleared on reset like any other state; sequential blocks use <= only.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr                  <= '0;
      dout_leaf_interface2bft <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= CREDIT_MAX;
        addr[i]   <= '0;
        dest[i]   <= '0;
      end
    end else begin
      rr_ptr                  <= rr_ptr_nxt;
      dout_leaf_interface2bft <= pkt_nxt;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (ack_interface2user[i]) addr[i] <= addr[i] + 1'b1;
        if (cfg_we && cfg_port == 3'(i)) dest[i] <= cfg_dest;
      end
    end
  end

`ifdef LEAF_ARB_STATS_EN
  logic [31:0]              sent_cnt [NUM_OUT_PORTS];
  logic [31:0]              stall_cnt;
  logic [31:0]              resend_cnt;
  logic [31:0]              stat_nxt;
  logic                     any_stall;

  // A credit stall is any port holding valid data with no downstream space.
  always_comb begin
    any_stall = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (vld_user2interface[i] && credit[i] == '0) any_stall = 1'b1;
    end
  end

  // Statistics read mux: ports first, then the two stall counters at the top of the map.
  always_comb begin
    stat_nxt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (stat_sel == 4'(i)) stat_nxt = sent_cnt[i];
    end
    if (stat_sel == 4'd14) stat_nxt = stall_cnt;
    if (stat_sel == 4'd15) stat_nxt = resend_cnt;
  end

  // Counters wrap freely; read data is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      resend_cnt <= '0;
      stat_data  <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) sent_cnt[i] <= '0;
    end else begin
      if (any_stall) stall_cnt  <= stall_cnt + 1'b1;
      if (resend)    resend_cnt <= resend_cnt + 1'b1;
      stat_data <= stat_nxt;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (ack_interface2user[i]) sent_cnt[i] <= sent_cnt[i] + 1'b1;
      end
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_data       = '0;
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Self-checking bench for leaf_out_arbiter: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (resend stall, config timing,
// reset mid-stream, credit exhaustion/refill/saturation, optional statistics).
module tb_leaf_out_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] din;
  logic [1:0]  vld;
  logic [1:0]  ack;
  logic [48:0] dout;
  logic        resend;
  logic        cfg_we;
  logic [2:0]  cfg_port;
  logic [8:0]  cfg_dest;
  logic        credit_upd_vld;
  logic [2:0]  credit_upd_port;
  logic [3:0]  stat_sel;
  logic [31:0] stat_data;

  int checks   = 0;
  int failures = 0;

  logic [6:0] addr_m [2];
  logic [8:0] dest_m [2];

  localparam logic [8:0] D0 = {5'd3, 4'd2};
  localparam logic [8:0] D1 = {5'd7, 4'd9};

  typedef struct {
    logic [1:0]  vld;
    logic        resend;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  exp_ack;
    logic [48:0] exp_dout;
  } vec_t;

  vec_t tbl [10];

  leaf_out_arbiter dut (
    .clk                    (clk),
    .reset                  (reset),
    .din_leaf_user2interface(din),
    .vld_user2interface     (vld),
    .ack_interface2user     (ack),
    .dout_leaf_interface2bft(dout),
    .resend                 (resend),
    .cfg_we                 (cfg_we),
    .cfg_port               (cfg_port),
    .cfg_dest               (cfg_dest),
    .credit_upd_vld         (credit_upd_vld),
    .credit_upd_port        (credit_upd_port),
    .stat_sel               (stat_sel),
    .stat_data              (stat_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [48:0] mk_pkt(input logic [8:0] d, input logic [6:0] a,
                                         input logic [31:0] p);
    return {1'b1, d, a, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check ack mid-cycle, check dout after the edge.
  task automatic cyc(input logic [1:0] v, input logic rs, input logic [1:0] exp_ack,
                     input string nm);
    logic [31:0] p0, p1;
    logic [48:0] exp_d;
    p0 = $urandom;
    p1 = $urandom;
    vld = v;
    resend = rs;
    din = {p1, p0};
    #3;
    check({nm, "_ack"}, 64'(ack), 64'(exp_ack));
    exp_d = '0;
    if (exp_ack == 2'b01) begin
      exp_d = mk_pkt(dest_m[0], addr_m[0], p0);
      addr_m[0]++;
    end else if (exp_ack == 2'b10) begin
      exp_d = mk_pkt(dest_m[1], addr_m[1], p1);
      addr_m[1]++;
    end
    @(posedge clk); #1;
    check({nm, "_dout"}, 64'(dout), 64'(exp_d));
    if (cfg_we && cfg_port < 3'd2) dest_m[cfg_port[0]] = cfg_dest;
    cfg_we         = 1'b0;
    credit_upd_vld = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    vld   = 2'b00;
    resend = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    addr_m[0] = '0; addr_m[1] = '0;
    dest_m[0] = '0; dest_m[1] = '0;
  endtask

  task automatic give_credit(input logic [2:0] port);
    credit_upd_vld  = 1'b1;
    credit_upd_port = port;
  endtask

  initial begin
    reset = 1'b1; vld = '0; din = '0; resend = 1'b0;
    cfg_we = 1'b0; cfg_port = '0; cfg_dest = '0;
    credit_upd_vld = 1'b0; credit_upd_port = '0; stat_sel = '0;
    addr_m[0] = '0; addr_m[1] = '0; dest_m[0] = '0; dest_m[1] = '0;

    tbl[0] = '{2'b01, 1'b0, 32'hDEADBEEF, 32'h0,        2'b01, mk_pkt(D0, 7'd0, 32'hDEADBEEF)};
    tbl[1] = '{2'b01, 1'b0, 32'h12345678, 32'h0,        2'b01, mk_pkt(D0, 7'd1, 32'h12345678)};
    tbl[2] = '{2'b11, 1'b0, 32'hA0A0A0A0, 32'hB0B0B0B0, 2'b10, mk_pkt(D1, 7'd0, 32'hB0B0B0B0)};
    tbl[3] = '{2'b11, 1'b0, 32'hA1A1A1A1, 32'hB1B1B1B1, 2'b01, mk_pkt(D0, 7'd2, 32'hA1A1A1A1)};
    tbl[4] = '{2'b11, 1'b0, 32'hA2A2A2A2, 32'hB2B2B2B2, 2'b10, mk_pkt(D1, 7'd1, 32'hB2B2B2B2)};
    tbl[5] = '{2'b00, 1'b0, 32'h11111111, 32'h22222222, 2'b00, 49'h0};
    tbl[6] = '{2'b10, 1'b0, 32'h0,        32'hC0C0C0C0, 2'b10, mk_pkt(D1, 7'd2, 32'hC0C0C0C0)};
    tbl[7] = '{2'b11, 1'b1, 32'h33333333, 32'h44444444, 2'b00, 49'h0};
    tbl[8] = '{2'b11, 1'b0, 32'hA3A3A3A3, 32'hB3B3B3B3, 2'b01, mk_pkt(D0, 7'd3, 32'hA3A3A3A3)};
    tbl[9] = '{2'b11, 1'b0, 32'hA4A4A4A4, 32'hB4B4B4B4, 2'b10, mk_pkt(D1, 7'd3, 32'hB4B4B4B4)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", 64'(dout), 64'h0);
    check("reset_ack", 64'(ack), 64'h0);
    reset = 1'b0;

    // Destinations
    cfg_we = 1'b1; cfg_port = 3'd0; cfg_dest = D0;
    cyc(2'b00, 1'b0, 2'b00, "cfg0");
    cfg_we = 1'b1; cfg_port = 3'd1; cfg_dest = D1;
    cyc(2'b00, 1'b0, 2'b00, "cfg1");

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      vld = tbl[i].vld;
      resend = tbl[i].resend;
      din = {tbl[i].d1, tbl[i].d0};
      #3;
      check($sformatf("vec%0d_ack", i), 64'(ack), 64'(tbl[i].exp_ack));
      @(posedge clk); #1;
      check($sformatf("vec%0d_dout", i), 64'(dout), 64'(tbl[i].exp_dout));
    end
    addr_m[0] = 7'd4; addr_m[1] = 7'd4;

    // Resend stall: pointer on port1 before the stall must still win after it
    cyc(2'b01, 1'b0, 2'b01, "pre_stall");
    for (int i = 0; i < 5; i++) cyc(2'b11, 1'b1, 2'b00, "stall");
    cyc(2'b11, 1'b0, 2'b10, "post_stall_p1");
    cyc(2'b11, 1'b0, 2'b01, "post_stall_p0");

    // Config in the same cycle as a grant uses the old destination
    cfg_we = 1'b1; cfg_port = 3'd0; cfg_dest = {5'd1, 4'd1};
    cyc(2'b01, 1'b0, 2'b01, "cfg_same_cycle");
    cyc(2'b01, 1'b0, 2'b01, "cfg_new_dest");
    cfg_we = 1'b1; cfg_port = 3'd5; cfg_dest = {5'd31, 4'd15};
    cyc(2'b00, 1'b0, 2'b00, "cfg_oor");
    cyc(2'b10, 1'b0, 2'b10, "cfg_oor_p1_kept");

    // Reset while both ports are valid and the pointer sits on port1
    cyc(2'b01, 1'b0, 2'b01, "pre_reset");
    vld = 2'b11; reset = 1'b1;
    #3;
    check("midrst_ack", 64'(ack), 64'h0);
    @(posedge clk); #1;
    check("midrst_dout", 64'(dout), 64'h0);
    reset = 1'b0;
    addr_m[0] = '0; addr_m[1] = '0; dest_m[0] = '0; dest_m[1] = '0;
    cyc(2'b11, 1'b0, 2'b01, "post_rst_first");

    // Port0 at 127; update saturates to 128, then drain all 128 (addr wraps)
    give_credit(3'd0);
    cyc(2'b00, 1'b0, 2'b00, "sat_upd");
    for (int i = 0; i < 128; i++) cyc(2'b01, 1'b0, 2'b01, "drain128");
    cyc(2'b11, 1'b0, 2'b10, "exhaust_p1a");
    cyc(2'b11, 1'b0, 2'b10, "exhaust_p1b");
    give_credit(3'd5);
    cyc(2'b01, 1'b0, 2'b00, "upd_oor");
    cyc(2'b01, 1'b0, 2'b00, "still_blocked");
    give_credit(3'd0);
    cyc(2'b11, 1'b0, 2'b10, "upd_cycle");
    cyc(2'b11, 1'b0, 2'b01, "resume");
    for (int i = 0; i < 63; i++) cyc(2'b01, 1'b0, 2'b01, "drain64");
    cyc(2'b01, 1'b0, 2'b00, "blocked64");

    // Grant and update together: 50 - 1 + 64 = 113
    give_credit(3'd0);
    cyc(2'b00, 1'b0, 2'b00, "refill");
    for (int i = 0; i < 14; i++) cyc(2'b01, 1'b0, 2'b01, "to50");
    give_credit(3'd0);
    cyc(2'b01, 1'b0, 2'b01, "grant_and_upd");
    for (int i = 0; i < 113; i++) cyc(2'b01, 1'b0, 2'b01, "drain113");
    cyc(2'b01, 1'b0, 2'b00, "blocked113");

`ifdef LEAF_ARB_STATS_EN
    reset_dut();
    for (int i = 0; i < 10; i++) cyc(2'b01, 1'b0, 2'b01, "stat_send");
    for (int i = 0; i < 3; i++) cyc(2'b11, 1'b1, 2'b00, "stat_resend");
    vld = 2'b00; resend = 1'b0;
    stat_sel = 4'd0;  @(posedge clk); #1; check("stat_p0", 64'(stat_data), 64'd10);
    stat_sel = 4'd1;  @(posedge clk); #1; check("stat_p1", 64'(stat_data), 64'd0);
    stat_sel = 4'd15; @(posedge clk); #1; check("stat_resend", 64'(stat_data), 64'd3);
    stat_sel = 4'd14; @(posedge clk); #1; check("stat_stall", 64'(stat_data), 64'd0);
`else
    stat_sel = 4'd0; @(posedge clk); #1;
    check("stat_tied_zero", 64'(stat_data), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
